data_mem_unit: RTL

DATA_MEM_UNIT -- requirements
Module: data_mem_unit

---
 rtl/data_mem_unit_pkg.sv | 61 ++++++
 rtl/data_mem_unit_if.sv | 27 ++
 rtl/data_mem_unit_bank.sv | 23 ++
 rtl/data_mem_unit.sv | 103 ++++++++++
 4 files changed

// File: rtl/data_mem_unit_pkg.sv
// Shared encodings and helpers for the data memory unit: access sizes, FSM states,
// byte-lane enables and load-data lane selection / extension.
package data_mem_unit_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_X = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RESP    = 2'd2
  } state_e;

  function automatic logic size_err(input logic [1:0] size, input logic [1:0] off);
    logic err;
    case (size)
      SIZE_B:  err = 1'b0;
      SIZE_H:  err = off[0];
      SIZE_W:  err = (off != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  function automatic logic [3:0] lane_we(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] we;
    case (size)
      SIZE_B:  we = 4'b0001 << off;
      SIZE_H:  we = off[1] ? 4'b1100 : 4'b0011;
      SIZE_W:  we = 4'b1111;
      default: we = 4'b0000;
    endcase
    return we;
  endfunction

  function automatic logic [31:0] lane_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_B:  res = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      SIZE_H:  res = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      SIZE_W:  res = word;
      default: res = 32'h00000000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/data_mem_unit_if.sv
// Request/response bus of the data memory unit; the requester is the master.
interface data_mem_unit_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wr;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_unit_bank.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module data_bank_bwe #(
  parameter int WORD_AW = 14
) (
  input  logic               clk,
  input  logic               en,
  input  logic [3:0]         we,
  input  logic [WORD_AW-1:0] addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata
);
  logic [31:0] mem_r [0:(2**WORD_AW)-1];

  // Byte-lane writes and synchronous read of the addressed word
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem_r[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
      rdata <= mem_r[addr];
    end
  end
endmodule

// File: rtl/data_mem_unit.sv
// Data memory unit: one request at a time, byte/half/word stores and extended loads
// on a byte-write-enable RAM, with a held response until the consumer accepts it.
module data_mem_unit
  import data_mem_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input logic            clk,
  input logic            rst,
  data_mem_unit_if.slave bus
);
  localparam int WORD_AW = ADDR_WIDTH - 2;

  state_e                state_r, state_s;
  logic [1:0]            size_r;
  logic [1:0]            off_r;
  logic                  uns_r;
  logic [DATA_WIDTH-1:0] rdata_r, rdata_s;
  logic                  err_r, err_s;
  logic                  accept_s;
  logic                  req_err_s;
  logic [3:0]            we_s;
  logic [DATA_WIDTH-1:0] wdata_s;
  logic [31:0]           ram_dout_s;

  assign accept_s  = (state_r == ST_IDLE) && bus.req_valid;
  assign req_err_s = size_err(bus.req_size, bus.req_addr[1:0]);
  assign we_s      = (accept_s && bus.req_wr && !req_err_s) ?
                     lane_we(bus.req_size, bus.req_addr[1:0]) : 4'b0000;

  // Replicate right-aligned store data onto every lane it could target
  always_comb begin
    wdata_s = bus.req_wdata;
    case (bus.req_size)
      SIZE_B:  wdata_s = {4{bus.req_wdata[7:0]}};
      SIZE_H:  wdata_s = {2{bus.req_wdata[15:0]}};
      default: wdata_s = bus.req_wdata;
    endcase
  end

  data_bank_bwe #(.WORD_AW(WORD_AW)) u_bank (
    .clk   (clk),
    .en    (accept_s),
    .we    (we_s),
    .addr  (bus.req_addr[ADDR_WIDTH-1:2]),
    .wdata (wdata_s),
    .rdata (ram_dout_s)
  );

  // Next-state and response data
  always_comb begin
    state_s = state_r;
    rdata_s = rdata_r;
    err_s   = err_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.req_valid) begin
          err_s   = req_err_s;
          rdata_s = '0;
          state_s = (bus.req_wr || req_err_s) ? ST_RESP : ST_RD_WAIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        rdata_s = lane_extend(ram_dout_s, size_r, off_r, uns_r);
        state_s = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_s = ST_IDLE;
        else               state_s = ST_RESP;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, sampled request attributes and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      rdata_r <= '0;
      err_r   <= 1'b0;
      size_r  <= 2'b00;
      off_r   <= 2'b00;
      uns_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      rdata_r <= rdata_s;
      err_r   <= err_s;
      if (accept_s) begin
        size_r <= bus.req_size;
        off_r  <= bus.req_addr[1:0];
        uns_r  <= bus.req_unsigned;
      end
    end
  end

  assign bus.req_ready = (state_r == ST_IDLE);
  assign bus.rsp_valid = (state_r == ST_RESP);
  assign bus.rsp_rdata = rdata_r;
  assign bus.rsp_err   = err_r;
endmodule
